// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: steps each instruction through its states,
// drives datapath selects and strobes, traps on illegal opcodes or memory timeouts.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  FETCH     | read instruction at PC, PC+4; waits mem_ready
//  DECODE    | latch opcode, branch target into ALUOut
//  MEM_ADDR  | A + sign-ext imm (load/store address)
//  MEM_READ  | load data read; waits mem_ready
//  MEM_WB    | MDR -> rt
//  MEM_WRITE | store data write; waits mem_ready
//  R_EXEC    | A funct B
//  R_WB      | ALUOut -> rd
//  I_EXEC    | A op imm
//  I_WB      | ALUOut -> rt
//  BRANCH    | compare A-B, conditional PC load from ALUOut
//  JUMP      | PC <- jump target
//  TRAP      | parked, all strobes low until reset
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_next;
  logic [5:0] op_q;
  logic [7:0] wait_cnt;
  logic       trap_q;
  logic [1:0] cause_q, cause_next;
  logic       waiting, timeout_hit, retire_evt;

  assign waiting     = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  // mem_ready on the last allowed cycle still completes the access
  assign timeout_hit = waiting && !mem_ready && (wait_cnt == WAIT_LAST);
  assign retire_evt  = (state == S_MEM_WB) || (state == S_R_WB) || (state == S_I_WB) ||
                       (state == S_BRANCH) || (state == S_JUMP) ||
                       ((state == S_MEM_WRITE) && mem_ready);

  always_comb begin
    state_next = state;
    cause_next = 2'b00;
    case (state)
      S_FETCH: begin
        if (mem_ready)        state_next = S_DECODE;
        else if (timeout_hit) begin state_next = S_TRAP; cause_next = 2'b10; end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:                               state_next = S_R_EXEC;
          OP_LW, OP_SW:                       state_next = S_MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_next = S_I_EXEC;
          OP_BEQ:                             state_next = S_BRANCH;
          OP_J:                               state_next = S_JUMP;
          default: begin state_next = S_TRAP; cause_next = 2'b01; end
        endcase
      end
      S_MEM_ADDR:  state_next = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem_ready)        state_next = S_MEM_WB;
        else if (timeout_hit) begin state_next = S_TRAP; cause_next = 2'b10; end
      end
      S_MEM_WRITE: begin
        if (mem_ready)        state_next = S_FETCH;
        else if (timeout_hit) begin state_next = S_TRAP; cause_next = 2'b10; end
      end
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_next = S_FETCH;
      S_R_EXEC:    state_next = S_R_WB;
      S_I_EXEC:    state_next = S_I_WB;
      S_TRAP:      state_next = S_TRAP;
      default:     state_next = S_TRAP;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    pc_source     = 2'b00;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEM_READ: begin mem_read = 1'b1; i_or_d = 1'b1; end
      S_MEM_WB:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      S_MEM_WRITE: begin mem_write = 1'b1; i_or_d = 1'b1; end
      S_R_EXEC:   begin alu_src_a = 1'b1; alu_op = 3'b010; end
      S_R_WB:     begin reg_write = 1'b1; reg_dst = 1'b1; end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op_q)
          OP_ANDI: alu_op = 3'b011;
          OP_ORI:  alu_op = 3'b100;
          OP_SLTI: alu_op = 3'b101;
          default: alu_op = 3'b000;
        endcase
      end
      S_I_WB:     reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP:     begin pc_write = 1'b1; pc_source = 2'b10; end
      default: ;
    endcase
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      op_q     <= 6'b000000;
      wait_cnt <= 8'd0;
      trap_q   <= 1'b0;
      cause_q  <= 2'b00;
      retired  <= '0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) op_q <= opcode;
      if (state_next != state)          wait_cnt <= 8'd0;
      else if (waiting && !mem_ready)   wait_cnt <= wait_cnt + 8'd1;
      if ((state_next == S_TRAP) && (state != S_TRAP)) begin
        trap_q  <= 1'b1;
        cause_q <= cause_next;
      end
      if (retire_evt) retired <= retired + CNT_W'(1);
    end
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; control outputs are compared as one
// packed vector against hand-built per-state constants.
module tb_multicycle_control_fsm;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, pc_source, trap_cause;
  logic [2:0]  alu_op;
  logic        trap;
  logic [31:0] retired;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  // {pw,pwc,iod,mr,mw,irw,m2r,rd,rw,asa}_srcb_aluop_pcsrc
  logic [16:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  localparam logic [16:0] C_FETCH_R = 17'b1001010000_01_000_00;
  localparam logic [16:0] C_FETCH_W = 17'b0001000000_01_000_00;
  localparam logic [16:0] C_DECODE  = 17'b0000000000_11_000_00;
  localparam logic [16:0] C_MADDR   = 17'b0000000001_10_000_00;
  localparam logic [16:0] C_MREAD   = 17'b0011000000_00_000_00;
  localparam logic [16:0] C_MWB     = 17'b0000001010_00_000_00;
  localparam logic [16:0] C_MWRITE  = 17'b0010100000_00_000_00;
  localparam logic [16:0] C_REXEC   = 17'b0000000001_00_010_00;
  localparam logic [16:0] C_RWB     = 17'b0000000110_00_000_00;
  localparam logic [16:0] C_IWB     = 17'b0000000010_00_000_00;
  localparam logic [16:0] C_BRANCH  = 17'b0100000001_00_001_01;
  localparam logic [16:0] C_JUMP    = 17'b1000000000_00_000_10;
  localparam logic [16:0] C_ZERO    = 17'b0;

  function automatic logic [16:0] c_iexec(input logic [2:0] op);
    return {10'b0000000001, 2'b10, op, 2'b00};
  endfunction

  task automatic apply_reset;
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_add_unchecked;
    for (int i = 0; i < 4; i++) begin
      opcode = 6'b000000; mem_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    checks++;
    if (ctrl !== 17'b0000000000_01_000_00) begin
      failures++; $display("FAIL reset_ctrl got %b expected %b", ctrl, 17'b0000000000_01_000_00);
    end
    checks++;
    if ({trap, trap_cause} !== 3'b000) begin
      failures++; $display("FAIL reset_trap got %b expected 000", {trap, trap_cause});
    end
    checks++;
    if (retired !== 32'd0) begin
      failures++; $display("FAIL reset_retired got %0d expected 0", retired);
    end
    reset = 1'b0;
  endtask

  task automatic test_add;
    logic [16:0] e [4];
    e = '{C_FETCH_R, C_DECODE, C_REXEC, C_RWB};
    apply_reset;
    for (int i = 0; i < 4; i++) begin
      opcode = 6'b000000; mem_ready = 1'b1; #1;
      checks++;
      if (ctrl !== e[i]) begin
        failures++; $display("FAIL add_cycle%0d got %b expected %b", i + 1, ctrl, e[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (retired !== 32'd1) begin
      failures++; $display("FAIL add_retired got %0d expected 1", retired);
    end
  endtask

  task automatic test_lw_wait;
    logic [16:0] e [8];
    logic        r [8];
    e = '{C_FETCH_R, C_DECODE, C_MADDR, C_MREAD, C_MREAD, C_MREAD, C_MREAD, C_MWB};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset;
    for (int i = 0; i < 8; i++) begin
      opcode = (i < 2) ? 6'b100011 : 6'b111111; mem_ready = r[i]; #1;
      checks++;
      if (ctrl !== e[i]) begin
        failures++; $display("FAIL lw_cycle%0d got %b expected %b", i + 1, ctrl, e[i]);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1; #1;
    checks++;
    if (retired !== 32'd1 || ctrl !== C_FETCH_R) begin
      failures++; $display("FAIL lw_done retired=%0d ctrl=%b expected 1 %b", retired, ctrl, C_FETCH_R);
    end
  endtask

  task automatic test_timeout;
    apply_reset;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0; #1;
      checks++;
      if (ctrl !== C_FETCH_W) begin
        failures++; $display("FAIL timeout_wait%0d got %b expected %b", i + 1, ctrl, C_FETCH_W);
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = i[0]; #1;
      checks++;
      if (ctrl !== C_ZERO || trap !== 1'b1 || trap_cause !== 2'b10) begin
        failures++;
        $display("FAIL timeout_trap%0d ctrl=%b trap=%b cause=%b expected %b 1 10", i, ctrl, trap, trap_cause, C_ZERO);
      end
      @(posedge clk); #1;
    end
    apply_reset; #1;
    checks++;
    if (trap !== 1'b0 || trap_cause !== 2'b00 || ctrl !== C_FETCH_R) begin
      failures++; $display("FAIL timeout_clear trap=%b cause=%b ctrl=%b expected 0 00 %b", trap, trap_cause, ctrl, C_FETCH_R);
    end
  endtask

  task automatic test_illegal;
    apply_reset;
    run_add_unchecked;
    for (int i = 0; i < 2; i++) begin
      opcode = 6'b111111; mem_ready = 1'b1;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      opcode = 6'b000000; #1;
      checks++;
      if (ctrl !== C_ZERO || trap !== 1'b1 || trap_cause !== 2'b01 || retired !== 32'd1) begin
        failures++;
        $display("FAIL illegal_trap%0d ctrl=%b trap=%b cause=%b retired=%0d expected %b 1 01 1", i, ctrl, trap, trap_cause, retired, C_ZERO);
      end
      @(posedge clk); #1;
    end
    apply_reset; #1;
    checks++;
    if (trap !== 1'b0 || trap_cause !== 2'b00 || retired !== 32'd0 || ctrl !== C_FETCH_R) begin
      failures++;
      $display("FAIL illegal_reset trap=%b cause=%b retired=%0d ctrl=%b expected 0 00 0 %b", trap, trap_cause, retired, ctrl, C_FETCH_R);
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0]  ops   [6];
    logic [2:0]  aluop [4];
    logic [16:0] ex;
    ops   = '{6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000100, 6'b000010};
    aluop = '{3'b000, 3'b011, 3'b100, 3'b101};
    apply_reset;
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < ((k < 4) ? 4 : 3); c++) begin
        mem_ready = 1'b1;
        // opcode is scrambled after DECODE to show it is latched
        opcode = (c < 2) ? ops[k] : 6'b111111;
        case (c)
          0: ex = C_FETCH_R;
          1: ex = C_DECODE;
          2: ex = (k < 4) ? c_iexec(aluop[k]) : ((k == 4) ? C_BRANCH : C_JUMP);
          default: ex = C_IWB;
        endcase
        #1;
        checks++;
        if (ctrl !== ex) begin
          failures++; $display("FAIL seq_instr%0d_cycle%0d got %b expected %b", k, c + 1, ctrl, ex);
        end
        @(posedge clk); #1;
      end
    end
    opcode = 6'b000000; mem_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (retired !== 32'd6) begin
      failures++; $display("FAIL seq_retired got %0d expected 6", retired);
    end
  endtask

  task automatic test_sw_lw;
    logic [16:0] e [9];
    logic [5:0]  o [9];
    e = '{C_FETCH_R, C_DECODE, C_MADDR, C_MWRITE, C_FETCH_R, C_DECODE, C_MADDR, C_MREAD, C_MWB};
    o = '{6'b101011, 6'b101011, 6'b0, 6'b0, 6'b100011, 6'b100011, 6'b0, 6'b0, 6'b0};
    apply_reset;
    for (int i = 0; i < 9; i++) begin
      opcode = o[i]; mem_ready = 1'b1; #1;
      checks++;
      if (ctrl !== e[i]) begin
        failures++; $display("FAIL swlw_cycle%0d got %b expected %b", i + 1, ctrl, e[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (retired !== 32'd2) begin
      failures++; $display("FAIL swlw_retired got %0d expected 2", retired);
    end
  endtask

  task automatic test_reset_mid_write;
    logic [16:0] e [4];
    logic        r [4];
    e = '{C_FETCH_R, C_DECODE, C_MADDR, C_MWRITE};
    r = '{1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset;
    run_add_unchecked;
    checks++;
    if (retired !== 32'd1) begin
      failures++; $display("FAIL midw_pre_retired got %0d expected 1", retired);
    end
    for (int i = 0; i < 4; i++) begin
      opcode = 6'b101011; mem_ready = r[i]; #1;
      checks++;
      if (ctrl !== e[i]) begin
        failures++; $display("FAIL midw_cycle%0d got %b expected %b", i + 1, ctrl, e[i]);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1; mem_ready = 1'b1; #1;
    checks++;
    if (ctrl !== 17'b0010000000_00_000_00) begin
      failures++; $display("FAIL midw_reset_strobes got %b expected %b", ctrl, 17'b0010000000_00_000_00);
    end
    @(posedge clk); #1;
    reset = 1'b0; #1;
    checks++;
    if (ctrl !== C_FETCH_R || retired !== 32'd0 || trap !== 1'b0) begin
      failures++; $display("FAIL midw_after ctrl=%b retired=%0d trap=%b expected %b 0 0", ctrl, retired, trap, C_FETCH_R);
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = 6'b0;
    test_reset;
    test_add;
    test_lw_wait;
    test_timeout;
    test_illegal;
    test_back_to_back;
    test_sw_lw;
    test_reset_mid_write;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
